// File: rtl/ex_ctrl_pkg.sv
// ex_ctrl_pkg: shared EX-stage control types and multiply sizing constants.
package ex_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;
  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 5;
endpackage

// File: rtl/mul_iter_datapath.sv
// mul_iter_datapath: radix-2 shift-add M/Q/ACC registers; q_last exists only with EX_MUL_EARLY_EXIT_EN.
module mul_iter_datapath
  import ex_ctrl_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] acc_init,
  output logic [WIDTH-1:0] acc_next
`ifdef EX_MUL_EARLY_EXIT_EN
  ,
  output logic             q_last
`endif
);
  logic [WIDTH-1:0] m_q, m_d, q_q, q_d, acc_q, acc_d;
  always_comb begin
    m_d   = load ? op_a : step ? m_q << 1 : m_q;
    q_d   = load ? op_b : step ? q_q >> 1 : q_q;
    acc_d = load ? acc_init : (step && q_q[0]) ? acc_q + m_q : acc_q;
  end
  assign acc_next = acc_d;
`ifdef EX_MUL_EARLY_EXIT_EN
  // No multiplier bits remain after this step, so ACC is already final.
  assign q_last = q_q[WIDTH-1:1] == '0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q   <= '0;
      q_q   <= '0;
      acc_q <= '0;
    end else begin
      m_q   <= m_d;
      q_q   <= q_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/ex_mul_sequencer.sv
// ex_mul_sequencer: EX-stage MUL/MLA controller that stalls the pipeline until the product retires.
// Optional early termination on an exhausted multiplier is built when EX_MUL_EARLY_EXIT_EN is defined.
module ex_mul_sequencer
  import ex_ctrl_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             accumulate,
  input  logic             s_bit,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] acc_in,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             status_wr,
  output logic [1:0]       status_nz
);
  mul_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s_q, s_d, valid_q, valid_d, wr_q, wr_d;
  logic [WIDTH-1:0] result_q, result_d, acc_next;
  logic [1:0]       status_nz_q, status_nz_d;
  logic             accept, step, last, fin;
  assign accept = state_q == IDLE && start && !flush;
  assign step   = state_q == BUSY;
`ifdef EX_MUL_EARLY_EXIT_EN
  logic q_last;
  assign last = cnt_q == CNT_W'(WIDTH - 1) || q_last;
`else
  assign last = cnt_q == CNT_W'(WIDTH - 1);
`endif
  mul_iter_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .step     (step),
    .op_a     (op_a),
    .op_b     (op_b),
    .acc_init (accumulate ? acc_in : '0),
    .acc_next (acc_next)
`ifdef EX_MUL_EARLY_EXIT_EN
    ,
    .q_last   (q_last)
`endif
  );
  // Result and flags are captured on the BUSY->DONE edge so they are registered during DONE.
  always_comb begin
    fin         = step && !flush && last;
    state_d     = accept ? BUSY : step ? (flush ? IDLE : last ? DONE : BUSY) : IDLE;
    cnt_d       = accept ? '0 : step ? cnt_q + CNT_W'(1) : cnt_q;
    s_d         = accept ? s_bit : s_q;
    valid_d     = fin;
    wr_d        = fin && s_q;
    result_d    = fin ? acc_next : result_q;
    status_nz_d = fin ? {acc_next[WIDTH-1], acc_next == '0} : status_nz_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      s_q         <= 1'b0;
      valid_q     <= 1'b0;
      wr_q        <= 1'b0;
      result_q    <= '0;
      status_nz_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      valid_q     <= valid_d;
      wr_q        <= wr_d;
      result_q    <= result_d;
      status_nz_q <= status_nz_d;
    end
  end
  assign stall        = accept || step;
  assign busy         = state_q != IDLE;
  assign result_valid = valid_q;
  assign result       = result_q;
  assign status_wr    = wr_q;
  assign status_nz    = status_nz_q;
endmodule

// File: tb/tb_ex_mul_sequencer.sv
// tb_ex_mul_sequencer: directed checks of MUL/MLA latency, results, flags, flush and reset.
module tb_ex_mul_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, accumulate, s_bit, flush;
  logic [31:0] op_a, op_b, acc_in, result;
  logic        stall, busy, result_valid, status_wr;
  logic [1:0]  status_nz;
  int          checks = 0;
  int          errors = 0;
  int          lat, st;
`ifdef EX_MUL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  ex_mul_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .accumulate   (accumulate),
    .s_bit        (s_bit),
    .op_a         (op_a),
    .op_b         (op_b),
    .acc_in       (acc_in),
    .flush        (flush),
    .stall        (stall),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .status_wr    (status_wr),
    .status_nz    (status_nz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Cycle index of DONE relative to the accept cycle T0.
  function automatic int exp_lat(input logic [31:0] b);
    int hb = 0;
    for (int i = 0; i < 32; i++) if (b[i]) hb = i + 1;
    return EE ? 1 + ((hb > 1) ? hb : 1) : 33;
  endfunction

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                     input logic ac, input logic sb, output int l, output int s);
    op_a = a; op_b = b; acc_in = c; accumulate = ac; s_bit = sb; start = 1'b1;
    #1;
    l = 0;
    s = 0;
    while (!result_valid && l < 100) begin
      if (stall) s++;
      @(negedge clk);
      start = 1'b0;
      #1;
      l++;
    end
  endtask

  task automatic after_done(input string tag, input logic [31:0] held);
    @(negedge clk);
    #1;
    chk({tag, "_valid_drop"}, {31'b0, result_valid}, 32'd0);
    chk({tag, "_result_hold"}, result, held);
    chk({tag, "_wr_drop"}, {31'b0, status_wr}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; accumulate = 1'b0; s_bit = 1'b0; flush = 1'b0;
    op_a = '0; op_b = '0; acc_in = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, result_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_wr", {31'b0, status_wr}, 32'd0);
    chk("rst_nz", {30'b0, status_nz}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(32'd3, 32'd5, 32'd0, 1'b0, 1'b1, lat, st);
    chk("mul3x5_lat", lat, exp_lat(32'd5));
    chk("mul3x5_stall_cycles", st, exp_lat(32'd5));
    chk("mul3x5_result", result, 32'd15);
    chk("mul3x5_nz", {30'b0, status_nz}, 32'd0);
    chk("mul3x5_wr", {31'b0, status_wr}, 32'd1);
    chk("mul3x5_stall_done", {31'b0, stall}, 32'd0);
    after_done("mul3x5", 32'd15);

    run(32'hFFFF_FFFF, 32'd2, 32'd1, 1'b1, 1'b0, lat, st);
    chk("mla_lat", lat, exp_lat(32'd2));
    chk("mla_result", result, 32'hFFFF_FFFF);
    chk("mla_nz", {30'b0, status_nz}, 32'd2);
    chk("mla_wr_sbit0", {31'b0, status_wr}, 32'd0);
    after_done("mla", 32'hFFFF_FFFF);

    run(32'h1_0000, 32'h1_0000, 32'd0, 1'b0, 1'b1, lat, st);
    chk("mulzero_lat", lat, exp_lat(32'h1_0000));
    chk("mulzero_result", result, 32'd0);
    chk("mulzero_nz", {30'b0, status_nz}, 32'd1);
    chk("mulzero_wr", {31'b0, status_wr}, 32'd1);
    after_done("mulzero", 32'd0);

    run(32'h1234, 32'd0, 32'd7, 1'b1, 1'b1, lat, st);
    chk("mlab0_lat", lat, exp_lat(32'd0));
    chk("mlab0_result", result, 32'd7);
    chk("mlab0_nz", {30'b0, status_nz}, 32'd0);
    after_done("mlab0", 32'd7);

    op_a = 32'd11; op_b = 32'hFFFF_FFFF; accumulate = 1'b0; s_bit = 1'b1; start = 1'b1;
    #1;
    chk("flush_t0_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_t10_busy", {31'b0, busy}, 32'd1);
    chk("flush_t10_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_t11_busy", {31'b0, busy}, 32'd0);
    chk("flush_t11_stall", {31'b0, stall}, 32'd0);
    chk("flush_t11_valid", {31'b0, result_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("flush_t12_valid", {31'b0, result_valid}, 32'd0);
    run(32'd6, 32'd7, 32'd0, 1'b0, 1'b1, lat, st);
    chk("post_flush_lat", lat, exp_lat(32'd7));
    chk("post_flush_result", result, 32'd42);
    after_done("post_flush", 32'd42);

    op_a = 32'd9; op_b = 32'h900; accumulate = 1'b0; s_bit = 1'b1; start = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("rstmid_t5_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_busy", {31'b0, busy}, 32'd0);
    chk("rstmid_valid", {31'b0, result_valid}, 32'd0);
    chk("rstmid_result", result, 32'd0);
    chk("rstmid_wr", {31'b0, status_wr}, 32'd0);
    chk("rstmid_nz", {30'b0, status_nz}, 32'd0);
    chk("rstmid_reaccept_stall", {31'b0, stall}, 32'd1);
    run(32'd9, 32'h900, 32'd0, 1'b0, 1'b1, lat, st);
    chk("rstmid_lat", lat, exp_lat(32'h900));
    chk("rstmid_result_final", result, 32'h5100);
    after_done("rstmid", 32'h5100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
